// File: rtl/rand_dispenser.sv
// rtl/rand_dispenser.sv - PRNG capture buffer serving 128-bit entries as WORD_W mask slices
// Seeds an external PRNG, captures one value every STRIDE advances into a FIFO, serves slices LSB-first.
module rand_dispenser #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  parameter int STRIDE = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      seed_i,
  input  logic              reseed_i,
  output logic              prng_init_o,
  output logic              prng_en_o,
  output logic [127:0]      prng_seed_o,
  input  logic [127:0]      prng_i,
  output logic              rnd_valid_o,
  input  logic              rnd_ready_i,
  output logic [WORD_W-1:0] rnd_o,
  output logic              seeded_o,
  output logic              underflow_o
);

  localparam int NSLICE = 128 / WORD_W;
  localparam int SIDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int CNT_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STRIDE - 1);
  localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(NSLICE - 1);
  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [127:0]      seed_q, seed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIDX_W-1:0] sidx_q, sidx_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [127:0]      mem_q [DEPTH];

  logic              is_full_w;
  logic              is_empty_w;
  logic              cnt_last_w;
  logic              xfer_w;
  logic              push_w;
  logic              pop_w;
  logic [127:0]      head_w;
  logic [WORD_W-1:0] slices_w [NSLICE];

  assign is_full_w   = (occ_q == OCC_FULL);
  assign is_empty_w  = (occ_q == '0);
  assign cnt_last_w  = (cnt_q == CNT_LAST);
  assign head_w      = mem_q[rd_ptr_q];
  assign prng_seed_o = seed_q;

  always_comb begin
    for (int i = 0; i < NSLICE; i++) begin
      slices_w[i] = head_w[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    cnt_d       = cnt_q;
    sidx_d      = sidx_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    prng_init_o = 1'b0;
    prng_en_o   = 1'b0;
    rnd_valid_o = 1'b0;
    rnd_o       = '0;
    seeded_o    = 1'b0;
    underflow_o = 1'b0;
    xfer_w      = 1'b0;
    push_w      = 1'b0;
    pop_w       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (reseed_i) begin
          seed_d  = seed_i;
          state_d = ST_SEED;
        end
      end

      ST_SEED: begin
        prng_init_o = 1'b1;
        state_d     = ST_SETTLE;
      end

      ST_SETTLE: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        seeded_o    = 1'b1;
        // Stall the PRNG only when a capture is due and there is nowhere to put it.
        prng_en_o   = !(is_full_w && cnt_last_w);
        rnd_valid_o = !is_empty_w;
        rnd_o       = is_empty_w ? '0 : slices_w[sidx_q];
        underflow_o = rnd_ready_i && is_empty_w;
        xfer_w      = rnd_valid_o && rnd_ready_i;
        push_w      = prng_en_o && cnt_last_w;
        pop_w       = xfer_w && (sidx_q == SIDX_LAST);

        if (prng_en_o) begin
          cnt_d = cnt_last_w ? '0 : cnt_q + CNT_W'(1);
        end
        if (xfer_w) begin
          sidx_d = (sidx_q == SIDX_LAST) ? '0 : sidx_q + SIDX_W'(1);
        end
        if (pop_w) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_w) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push_w, pop_w})
          2'b10:   occ_d = occ_q + OCC_W'(1);
          2'b01:   occ_d = occ_q - OCC_W'(1);
          default: occ_d = occ_q;
        endcase

        // A reseed discards everything captured under the old seed.
        if (reseed_i) begin
          push_w   = 1'b0;
          seed_d   = seed_i;
          cnt_d    = '0;
          sidx_d   = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          occ_d    = '0;
          state_d  = ST_SEED;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      seed_q   <= '0;
      cnt_q    <= '0;
      sidx_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      sidx_q   <= sidx_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is never reset; it is only visible through a non-empty head.
  always_ff @(posedge clk) begin
    if (!rst && push_w) begin
      mem_q[wr_ptr_q] <= prng_i;
    end
  end

endmodule

// File: tb/tb_rand_dispenser.sv
// tb/tb_rand_dispenser.sv - self-checking bench for rand_dispenser against a queue-based reference model
module tb_rand_dispenser;
  localparam int WW = 32;
  localparam int DP = 4;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  seed_i;
  logic          reseed_i;
  logic          prng_init_o;
  logic          prng_en_o;
  logic [127:0]  prng_seed_o;
  logic [127:0]  prng_q = '0;
  logic          rnd_valid_o;
  logic          rnd_ready_i;
  logic [WW-1:0] rnd_o;
  logic          seeded_o;
  logic          underflow_o;

  always #5 clk = ~clk;

  rand_dispenser #(.WORD_W(WW), .DEPTH(DP), .STRIDE(ST)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_i     (seed_i),
    .reseed_i   (reseed_i),
    .prng_init_o(prng_init_o),
    .prng_en_o  (prng_en_o),
    .prng_seed_o(prng_seed_o),
    .prng_i     (prng_q),
    .rnd_valid_o(rnd_valid_o),
    .rnd_ready_i(rnd_ready_i),
    .rnd_o      (rnd_o),
    .seeded_o   (seeded_o),
    .underflow_o(underflow_o)
  );

  // Counter PRNG: load on init, +1 on enable.
  always @(posedge clk) begin
    if (prng_init_o === 1'b1) prng_q <= prng_seed_o;
    else if (prng_en_o === 1'b1) prng_q <= prng_q + 128'd1;
  end

  int           checks = 0;
  int           errors = 0;
  int           m_phase = 0;   // 0 idle, 1 seed, 2 settle, 3 run
  int           m_cnt = 0;
  int           m_sidx = 0;
  logic [127:0] m_q[$];
  logic [127:0] m_seed = '0;
  logic [127:0] m_prng = '0;
  logic [31:0]  served[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic rs, input logic rdy, input logic [127:0] sd);
    logic         e_en, e_valid, push;
    logic [31:0]  e_rnd;
    logic [127:0] entry, old_prng;
    @(negedge clk);
    rst = r; reseed_i = rs; rnd_ready_i = rdy; seed_i = sd;
    #1;
    e_en    = (m_phase == 3) && !(m_q.size() == DP && m_cnt == ST - 1);
    e_valid = (m_phase == 3) && (m_q.size() > 0);
    e_rnd   = '0;
    if (e_valid) begin
      entry = m_q[0];
      e_rnd = 32'(entry >> (m_sidx * WW));
    end
    check("prng_init", prng_init_o, m_phase == 1);
    check("prng_en", prng_en_o, e_en);
    check("prng_seed", prng_seed_o, m_seed);
    check("rnd_valid", rnd_valid_o, e_valid);
    check("rnd", rnd_o, e_rnd);
    check("seeded", seeded_o, m_phase == 3);
    check("underflow", underflow_o, (m_phase == 3) && rdy && !e_valid);
    if (rnd_valid_o === 1'b1 && rdy) served.push_back(rnd_o);
    @(posedge clk);
    if (r) begin
      m_phase = 0; m_q.delete(); m_cnt = 0; m_sidx = 0; m_seed = '0;
    end else begin
      old_prng = m_prng;
      if (m_phase == 1) m_prng = m_seed;
      else if (e_en) m_prng = m_prng + 128'd1;
      case (m_phase)
        0: if (rs) begin m_seed = sd; m_phase = 1; end
        1: m_phase = 2;
        2: begin m_phase = 3; m_cnt = 0; end
        default: begin
          push = e_en && (m_cnt == ST - 1);
          if (e_valid && rdy) begin
            m_sidx++;
            if (m_sidx == 128 / WW) begin
              m_sidx = 0;
              void'(m_q.pop_front());
            end
          end
          if (push) m_q.push_back(old_prng);
          if (e_en) m_cnt = (m_cnt + 1) % ST;
          if (rs) begin
            m_q.delete(); m_sidx = 0; m_cnt = 0; m_seed = sd; m_phase = 1;
          end
        end
      endcase
    end
  endtask

  initial begin
    int thr;
    rst = 1'b1; reseed_i = 1'b0; rnd_ready_i = 1'b0; seed_i = '0;
    repeat (2) @(posedge clk);
    cycle(1'b0, 1'b0, 1'b0, '0);

    // Seed 0x10 and walk through SEED / SETTLE.
    cycle(1'b0, 1'b1, 1'b0, 128'h10);
    #1 check("seed_strobe", prng_init_o, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0);
    #1 check("settle_init", prng_init_o, 1'b0);
    check("settle_seeded", seeded_o, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    #1 check("run_seeded", seeded_o, 1'b1);

    // No consumer: fill the buffer and stall.
    repeat (40) cycle(1'b0, 1'b0, 1'b0, '0);
    #1 check("full_en_stall", prng_en_o, 1'b0);
    check("full_head_hold", rnd_o, 32'h13);
    check("full_prng_value", prng_q, 128'h23);

    served.delete();
    repeat (4) cycle(1'b0, 1'b0, 1'b1, '0);
    check("first_entry_words", served.size(), 4);
    if (served.size() == 4) begin
      check("word0", served[0], 32'h13);
      check("word1", served[1], 32'h0);
      check("word2", served[2], 32'h0);
      check("word3", served[3], 32'h0);
    end
    #1 check("reenable_after_pop", prng_en_o, 1'b1);
    check("next_entry", rnd_o, 32'h17);

    served.delete();
    repeat (16) cycle(1'b0, 1'b0, 1'b1, '0);
    check("drain_words", served.size(), 16);
    if (served.size() >= 13) check("pushed_after_pop", served[12], 32'h23);

    // Reseed during slice 2, then an ignored reseed in SEED.
    for (int i = 0; i < 20 && m_sidx != 2; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    check("slice2_reached", m_sidx, 2);
    served.delete();
    cycle(1'b0, 1'b1, 1'b1, 128'h100);
    check("reseed_xfer_done", served.size(), 1);
    #1 check("flushed_valid", rnd_valid_o, 1'b0);
    check("new_seed", prng_seed_o, 128'h100);
    cycle(1'b0, 1'b1, 1'b1, 128'h999);
    #1 check("seed_reseed_ignored", prng_seed_o, 128'h100);
    served.delete();
    for (int i = 0; i < 30 && served.size() == 0; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    check("post_reseed_words", served.size(), 1);
    if (served.size() == 1) check("post_reseed_first", served[0], 32'h103);

    // Reset with a full buffer.
    repeat (40) cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, '0);
    #1 check("rst_init", prng_init_o, 1'b0);
    check("rst_en", prng_en_o, 1'b0);
    check("rst_seed", prng_seed_o, 128'h0);
    check("rst_valid", rnd_valid_o, 1'b0);
    check("rst_rnd", rnd_o, 32'h0);
    check("rst_seeded", seeded_o, 1'b0);
    check("rst_underflow", underflow_o, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b0, 128'h55);

    // Randomised traffic with occasional reseeds and resets.
    thr = 2;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) thr = int'($urandom_range(0, 4));
      cycle(($urandom % 400) == 0, ($urandom % 60) == 0, ($urandom % 4) < thr,
            {$urandom, $urandom, $urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
